// File: rtl/int_ctrl_pkg.sv
// int_ctrl shared definitions: register offsets, FSM
// state encoding and the width of a source ID.
package int_ctrl_pkg;

  localparam logic [3:0] IC_PENDING = 4'h0;
  localparam logic [3:0] IC_ENABLE  = 4'h4;
  localparam logic [3:0] IC_CLAIM   = 4'h8;
  localparam logic [3:0] IC_STATUS  = 4'hC;

  localparam int ID_W = 5;

  typedef enum logic {
    IDLE    = 1'b0,
    CLAIMED = 1'b1
  } ic_state_e;

endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl peripheral bus: req/we/addr/wdata in,
// registered rdata and one-cycle ack back.
interface int_ctrl_if;

  logic [31:0] data_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic        req_i;
  logic [31:0] data_o;
  logic        ack_o;

  modport master (
    output data_i, addr_i, we_i, req_i,
    input  data_o, ack_o
  );

  modport slave (
    input  data_i, addr_i, we_i, req_i,
    output data_o, ack_o
  );

endinterface

// File: rtl/int_ctrl_prio.sv
// Lowest-index-first priority encoder.
// req: request bits; id: index+1 of winner (0 if none); vld: any request.
module int_ctrl_prio
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic [ID_W-1:0]    id,
  output logic               vld
);

  // Scan high to low so the lowest set index is written last.
  always_comb begin
    id  = '0;
    vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        id  = ID_W'(i + 1);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: edge capture, enable mask, fixed priority, claim/complete.
// Ports: clk, rst (async active-low), bus (slave), irq_i, irq_o, irq_id_o.
// Option: INT_CTRL_SYNC_EN adds a two-flop synchronizer on irq_i.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               rst,
  int_ctrl_if.slave          bus,
  input  logic [NUM_SRC-1:0] irq_i,
  output logic               irq_o,
  output logic [7:0]         irq_id_o
);

  logic [NUM_SRC-1:0] pend;
  logic [NUM_SRC-1:0] en;
  logic [NUM_SRC-1:0] pe;
  logic [NUM_SRC-1:0] irq_s;
  logic [NUM_SRC-1:0] irq_q;
  logic [NUM_SRC-1:0] edg;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] clm_oh;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    isr_id;
  logic               win_vld;
  ic_state_e          state;
  logic [3:0]         off;
  logic               rd;
  logic               wr;
  logic               grant;
  logic               cmp;
  logic [31:0]        rdata;
  logic               unused;

`ifdef INT_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync1;
  logic [NUM_SRC-1:0] sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_i;
      sync2 <= sync1;
    end
  end

  assign irq_s = sync2;
`else
  assign irq_s = irq_i;
`endif

  assign off    = bus.addr_i[3:0];
  assign rd     = bus.req_i & ~bus.we_i;
  assign wr     = bus.req_i & bus.we_i;
  assign pe     = pend & en;
  assign edg    = irq_s & ~irq_q;
  assign unused = ^{bus.addr_i[31:4], bus.data_i};

  int_ctrl_prio #(
    .NUM_SRC(NUM_SRC)
  ) u_prio (
    .req(pe),
    .id (win_id),
    .vld(win_vld)
  );

  assign grant = rd && (off == IC_CLAIM)
              && (state == IDLE) && win_vld;
  assign cmp   = wr && (off == IC_CLAIM)
              && (state == CLAIMED)
              && (bus.data_i[ID_W-1:0] == isr_id);

  always_comb begin
    clm_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      clm_oh[i] = grant && (win_id == ID_W'(i + 1));
    end
  end

  assign clr = clm_oh
             | ((wr && (off == IC_PENDING))
                ? bus.data_i[NUM_SRC-1:0] : '0);

  always_comb begin
    rdata = '0;
    if (rd) begin
      unique case (1'b1)
        off == IC_PENDING: rdata = 32'(pend);
        off == IC_ENABLE:  rdata = 32'(en);
        off == IC_CLAIM:   rdata = grant ? 32'(win_id) : '0;
        off == IC_STATUS:  rdata = {26'b0, state, isr_id};
        default:           rdata = '0;
      endcase
    end
  end

  // A fresh edge is OR-ed in after the clear, so set wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend  <= '0;
      en    <= '0;
      irq_q <= '0;
    end else begin
      pend  <= (pend & ~clr) | edg;
      irq_q <= irq_s;
      if (wr && (off == IC_ENABLE)) begin
        en <= bus.data_i[NUM_SRC-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.ack_o  <= 1'b0;
      bus.data_o <= '0;
    end else begin
      bus.ack_o  <= bus.req_i;
      bus.data_o <= rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      isr_id   <= '0;
      irq_o    <= 1'b0;
      irq_id_o <= '0;
    end else begin
      irq_o    <= (state == IDLE) && win_vld;
      irq_id_o <= ((state == IDLE) && win_vld)
                  ? 8'(win_id) : 8'd0;
      case (state)
        IDLE: begin
          if (grant) begin
            state  <= CLAIMED;
            isr_id <= win_id;
          end
        end
        CLAIMED: begin
          if (cmp) begin
            state  <= IDLE;
            isr_id <= '0;
          end
        end
        default: begin
          state  <= IDLE;
          isr_id <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// int_ctrl bench: register table, directed claim/complete
// sequences and a randomized run against a behavioural model.
module tb_int_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq;
  logic       irq_o;
  logic [7:0] irq_id_o;
  logic [31:0] q;
  int total;
  int bad;

  int_ctrl_if b ();

  int_ctrl #(
    .NUM_SRC(8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (b.slave),
    .irq_i   (irq),
    .irq_o   (irq_o),
    .irq_id_o(irq_id_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  // behavioural model state
  int unsigned m_pend, m_en, m_prev, m_id;
  bit          m_busy;
  int unsigned e_data, e_id;
  bit          e_ack, e_irq;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic we, input logic [31:0] a,
                     input logic [31:0] d,
                     output logic [31:0] r);
    b.req_i  = 1'b1;
    b.we_i   = we;
    b.addr_i = a;
    b.data_i = d;
    tick();
    b.req_i = 1'b0;
    b.we_i  = 1'b0;
    chk("ack", {31'b0, b.ack_o}, 32'd1);
    r = b.data_o;
  endtask

  task automatic rdchk(input string nm, input logic [31:0] a,
                       input logic [31:0] exp);
    logic [31:0] r;
    bus(1'b0, a, 32'd0, r);
    chk(nm, r, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b1, a, d, r);
  endtask

  task automatic pulse(input logic [7:0] v);
    irq = v;
    tick();
    irq = 8'h0;
  endtask

  function automatic int unsigned winner();
    int unsigned w = 0;
    for (int i = 0; i < 8; i++) begin
      if (w == 0 && (((m_pend & m_en) >> i) & 1) == 1) w = i + 1;
    end
    return w;
  endfunction

  // Expected outputs after this edge, then next model state.
  task automatic model_cycle(input bit req, input bit we,
                             input int unsigned a,
                             input int unsigned wd,
                             input int unsigned iv);
    int unsigned w, off, clr;
    w      = winner();
    off    = a & 15;
    e_ack  = req;
    e_irq  = !m_busy && w != 0;
    e_id   = e_irq ? w : 0;
    e_data = 0;
    if (req && !we) begin
      case (off)
        0:  e_data = m_pend;
        4:  e_data = m_en;
        8:  e_data = m_busy ? 0 : w;
        12: e_data = (m_busy ? 32 : 0) + m_id;
        default: e_data = 0;
      endcase
    end
    clr = 0;
    if (req && we && off == 0) clr = wd & 255;
    if (req && we && off == 4) m_en = wd & 255;
    if (req && !we && off == 8 && !m_busy && w != 0) begin
      clr   |= 1 << (w - 1);
      m_busy = 1;
      m_id   = w;
    end else if (req && we && off == 8 && m_busy
                 && (wd & 31) == m_id) begin
      m_busy = 0;
      m_id   = 0;
    end
    m_pend = (m_pend & ~clr) | (iv & ~m_prev & 255);
    m_prev = iv;
  endtask

  task automatic do_reset();
    b.req_i = 1'b0;
    b.we_i  = 1'b0;
    irq     = 8'h0;
    rst     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    m_pend = 0; m_en = 0; m_prev = 0;
    m_id = 0; m_busy = 0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    irq   = 8'h0;
    b.req_i  = 1'b0;
    b.we_i   = 1'b0;
    b.addr_i = '0;
    b.data_i = '0;

    tbl[0] = '{"rd_pend",  1'b0, 32'h0,  32'h0,        32'h0};
    tbl[1] = '{"rd_en",    1'b0, 32'h4,  32'h0,        32'h0};
    tbl[2] = '{"rd_stat",  1'b0, 32'hC,  32'h0,        32'h0};
    tbl[3] = '{"wr_en",    1'b1, 32'h4,  32'hFFFFFFFF, 32'h0};
    tbl[4] = '{"rd_en_ff", 1'b0, 32'h4,  32'h0,        32'hFF};
    tbl[5] = '{"rd_unmap", 1'b0, 32'h2,  32'h0,        32'h0};
    tbl[6] = '{"wr_unmap", 1'b1, 32'h13, 32'hFFFF,     32'h0};
    tbl[7] = '{"claim_0",  1'b0, 32'h8,  32'h0,        32'h0};
    tbl[8] = '{"wr_en0",   1'b1, 32'hF4, 32'h0,        32'h0};
    tbl[9] = '{"rd_en_0",  1'b0, 32'h104, 32'h0,       32'h0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", {31'b0, b.ack_o}, 32'd0);
    chk("rst_data", b.data_o, 32'd0);
    chk("rst_irq", {31'b0, irq_o}, 32'd0);
    chk("rst_id", {24'b0, irq_id_o}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 10; i++) begin
      bus(tbl[i].we, tbl[i].a, tbl[i].d, q);
      if (!tbl[i].we) chk(tbl[i].nm, q, tbl[i].exp);
    end
    tick();
    chk("ack_one", {31'b0, b.ack_o}, 32'd0);

    // timer edge
    wr(32'h4, 32'h1);
    irq = 8'h1;
    tick();
    irq = 8'h0;
    chk("tmr_irq_n1", {31'b0, irq_o}, 32'd0);
    tick();
    chk("tmr_irq_n2", {31'b0, irq_o}, 32'd1);
    chk("tmr_id", {24'b0, irq_id_o}, 32'd1);
    rdchk("tmr_claim", 32'h8, 32'd1);
    tick();
    chk("tmr_irq_drop", {31'b0, irq_o}, 32'd0);
    chk("tmr_id_drop", {24'b0, irq_id_o}, 32'd0);
    rdchk("tmr_stat", 32'hC, 32'h21);
    wr(32'h8, 32'h1);
    rdchk("tmr_stat_idle", 32'hC, 32'h0);

    // priority
    wr(32'h4, 32'hFF);
    pulse(8'h0A);
    tick();
    chk("pri_id", {24'b0, irq_id_o}, 32'd2);
    rdchk("pri_claim2", 32'h8, 32'd2);
    wr(32'h8, 32'd2);
    tick();
    chk("pri_rerise", {31'b0, irq_o}, 32'd1);
    chk("pri_id4", {24'b0, irq_id_o}, 32'd4);
    rdchk("pri_claim4", 32'h8, 32'd4);
    wr(32'h8, 32'd4);

    // wrong complete
    pulse(8'h02);
    tick();
    rdchk("wc_claim", 32'h8, 32'd2);
    wr(32'h8, 32'd3);
    rdchk("wc_stat", 32'hC, 32'h22);
    rdchk("wc_claim0", 32'h8, 32'd0);
    wr(32'h8, 32'd2);
    rdchk("wc_done", 32'hC, 32'h0);

    // set wins over W1C
    wr(32'h4, 32'h0);
    pulse(8'h04);
    rdchk("sw_pend", 32'h0, 32'h4);
    irq = 8'h04;
    wr(32'h0, 32'h4);
    irq = 8'h0;
    rdchk("sw_setwin", 32'h0, 32'h4);
    wr(32'h0, 32'h4);
    rdchk("sw_clr", 32'h0, 32'h0);

    // masked pending
    pulse(8'h20);
    tick();
    tick();
    chk("mk_irq0", {31'b0, irq_o}, 32'd0);
    rdchk("mk_pend", 32'h0, 32'h20);
    wr(32'h4, 32'h20);
    chk("mk_irq_ack", {31'b0, irq_o}, 32'd0);
    tick();
    chk("mk_irq1", {31'b0, irq_o}, 32'd1);
    chk("mk_id6", {24'b0, irq_id_o}, 32'd6);

    // reset while claimed
    rdchk("rs_claim", 32'h8, 32'd6);
    pulse(8'h20);
    rdchk("rs_stat", 32'hC, 32'h26);
    #2;
    rst = 1'b0;
    #1;
    chk("rs_ack", {31'b0, b.ack_o}, 32'd0);
    chk("rs_data", b.data_o, 32'd0);
    #2;
    rst = 1'b1;
    tick();
    rdchk("rs_stat0", 32'hC, 32'h0);
    rdchk("rs_pend0", 32'h0, 32'h0);
    rdchk("rs_en0", 32'h4, 32'h0);

    // randomized run against the model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int unsigned op, off, wd, adr;
      bit rq, we;
      if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
      op = $urandom_range(0, 11);
      rq = 1; we = 0; off = 0; wd = $urandom;
      case (op)
        0, 1: rq = 0;
        2:    off = 0;
        3:    off = 4;
        4:    off = 12;
        5, 6: off = 8;
        7, 8: begin
          off = 8; we = 1;
          wd = ($urandom_range(0, 1) == 1) ? m_id
                                           : $urandom_range(0, 9);
        end
        9:    begin off = 0; we = 1; end
        10:   begin off = 4; we = 1; end
        default: begin
          off = $urandom_range(0, 15);
          we  = 1'($urandom_range(0, 1));
        end
      endcase
      adr = ($urandom & 32'hFFFFFFF0) | off;
      b.req_i  = rq;
      b.we_i   = we;
      b.addr_i = adr;
      b.data_i = wd;
      model_cycle(rq, we, adr, wd, {24'b0, irq});
      tick();
      chk("rnd_ack", {31'b0, b.ack_o}, {31'b0, e_ack});
      chk("rnd_irq", {31'b0, irq_o}, {31'b0, e_irq});
      chk("rnd_id", {24'b0, irq_id_o}, e_id);
      if (rq && !we) chk("rnd_data", b.data_o, e_data);
    end
    b.req_i = 1'b0;
    b.we_i  = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/int_ctrl.md
# int_ctrl

Memory-mapped interrupt controller that aggregates the peripheral interrupt lines (timer `int_sig_o`, UART, GPIO) and presents one prioritised request to the core. It sits directly downstream of the timer and the other peripherals. It captures rising edges into pending bits, masks them with an enable register and arbitrates by fixed priority. A claim/complete handshake over the peripheral bus tracks the one source in service.

## Interface
- `NUM_SRC`, default 8: number of interrupt sources, legal range 1..31; source `i` has ID `i+1`.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `data_i`, input, 32: bus write data.
- `addr_i`, input, 32: bus address; only `addr_i[3:0]` is decoded.
- `we_i`, input, 1: write enable, qualified by `req_i`.
- `req_i`, input, 1: bus access request.
- `data_o`, output, 32: registered read data, valid while `ack_o` is high.
- `ack_o`, output, 1: one-cycle access acknowledge.
- `irq_i`, input, `NUM_SRC`: level interrupt lines from peripherals; bit 0 is the timer.
- `irq_o`, output, 1: interrupt request to the core, registered.
- `irq_id_o`, output, 8: ID of the highest-priority pending enabled source; 0 when there is none.

## Operation
- Registers, decoded on `addr_i[3:0]`:
  - 0x0 PENDING: read; write-1-to-clear.
  - 0x4 ENABLE: read/write; bits at and above `NUM_SRC` read 0.
  - 0x8 CLAIM: a read claims; a write completes.
  - 0xC STATUS: `{26'b0, state, in_service_id[4:0]}`.
- Edge capture: `pend[i]` is set when `irq_i[i]` is high this cycle and was low in the previous sample.
- Priority: among `pend & en`, the lowest index wins. The result is encoded as index+1, zero-extended.
- State machine:
  - IDLE: no source is in service.
  - CLAIMED: `in_service_id` is nonzero.
- IDLE, CLAIM read with a winner present:
  - Returns the winner ID.
  - Clears that pending bit.
  - Latches `in_service_id` and moves to CLAIMED.
- IDLE, CLAIM read with no winner: returns 0; state unchanged.
- CLAIMED, CLAIM read: returns 0; no change.
- CLAIMED, CLAIM write where `data_i[4:0]` equals `in_service_id`: clears `in_service_id` and returns to IDLE. Any other value is ignored.
- IDLE, CLAIM write: ignored.
- `irq_o` is 1 only in IDLE with `|(pend & en)`. It is held 0 while CLAIMED, so there is no nesting.
- Boundary cases:
  - A new edge and a clear of the same pending bit in the same cycle (W1C or claim): the set wins.
  - A source that is disabled still latches pending. Enabling it later raises `irq_o`.
  - Reset mid-operation: all state is dropped immediately, whatever the bus or state-machine activity.
- Unmapped offsets: reads return 0, writes are ignored, and `ack_o` is still returned.

## Timing
- Reset values:
  - Outputs: `data_o`=0, `ack_o`=0, `irq_o`=0, `irq_id_o`=0.
  - Internal: pending=0, enable=0, state IDLE, `in_service_id`=0, edge samples=0.
- Bus:
  - A `req_i` high in cycle N gives `ack_o`=1 and `data_o` in cycle N+1, for exactly one cycle.
  - Back-to-back requests are acknowledged every cycle.
  - Write and claim side effects become visible in cycle N+1.
- Edge latency, without the synchronizer: an `irq_i` rise in cycle N sets pending at edge N+1, and `irq_o` rises at N+2 when the source is enabled and the state is IDLE.
- `irq_o` and `irq_id_o` drop the cycle after a claim is acknowledged.

## Configuration
- `INT_CTRL_SYNC_EN` defined: each `irq_i` bit passes through a two-flop synchronizer before edge detection. This adds 2 cycles to every edge latency, for asynchronous sources.
- `INT_CTRL_SYNC_EN` undefined: `irq_i` feeds edge detection directly, with a single sample flop. All sources must then be `clk`-synchronous.

## Structure
- `int_ctrl_pkg` holds:
  - Register offset constants (`IC_PENDING`, `IC_ENABLE`, `IC_CLAIM`, `IC_STATUS`).
  - The state encoding (IDLE=0, CLAIMED=1).
  - The ID width constant (5).
- Sub-module `int_ctrl_prio`: combinational lowest-index-first encoder. Input is `NUM_SRC` bits; outputs are a 5-bit ID and a valid flag.

## Test plan
- Reset: after `rst` is released, all outputs are 0 and PENDING/ENABLE/STATUS read 0.
- Timer edge with ENABLE=0x1:
  - Pulse `irq_i[0]`, then `irq_o` rises 2 cycles later with `irq_id_o`=1.
  - CLAIM read returns 1, then `irq_o`=0 and STATUS=0x21.
- Priority: raise `irq_i[3]` and `irq_i[1]` together with ENABLE=0xFF; the first claim returns 2.
  - Complete with 2, then `irq_o` re-rises and the next claim returns 4.
- Wrong complete: while CLAIMED with ID 2, write 3 to CLAIM; the state stays CLAIMED. A second claim read returns 0.
- Set-wins race: in the cycle a W1C of 0x4 is issued, an `irq_i[2]` edge is also captured; PENDING then reads 0x4.
- Masked pending: with ENABLE=0, an edge on `irq_i[5]` leaves `irq_o`=0. Writing ENABLE=0x20 raises `irq_o` the following cycle with `irq_id_o`=6.
